debounce_event_arbiter: RTL and testbench

Multi-channel switch/button front end. Synchronises N_CH raw asynchronous inputs and debounces each one against a shared prescaled time base. Each debounced edge becomes an event, and events from all channels are scheduled round-robin onto a single valid/ready event port. It sits between board-level pins and the control logic or CSR block that consumes button events.

---
 rtl/debounce_event_arbiter_if.sv | 30 +++
 rtl/debounce_event_arbiter.sv | 168 ++++++++++++++++
 tb/tb_debounce_event_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_event_arbiter_if.sv
// Event port of the debounce front end: a valid/ready stream carrying the
// channel number and edge direction of each debounced transition.
//   evt_valid  master->slave  event available
//   evt_ready  slave->master  consumer accepts the event this cycle
//   evt_ch     master->slave  channel that produced the event
//   evt_rise   master->slave  1 = rising edge, 0 = falling edge
interface debounce_event_arbiter_if #(
    parameter int unsigned N_CH = 4
);
    localparam int unsigned CH_W = $clog2(N_CH);

    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_rise;

    modport master (
        output evt_valid,
        output evt_ch,
        output evt_rise,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_rise,
        output evt_ready
    );
endinterface

// File: rtl/debounce_event_arbiter.sv
// Multi-channel switch debouncer with a round-robin event port.
// Each raw input is synchronised (2 flops), debounced against a shared
// prescaled tick, and every debounced edge is queued as a one-deep pending
// event per channel. Pending events are scheduled round-robin onto evt.
//   clk, rstb     clock, asynchronous active-low reset
//   enable        1 = prescaler and debounce counters run, 0 = frozen
//   prescale      tick period minus 1, in clk cycles
//   stable_ticks  ticks of stability required minus 1
//   raw_in        asynchronous raw switch inputs
//   db_out        debounced levels
//   ovf_flags     sticky: an undelivered event on the channel was overwritten
//   ovf_clr       clears all ovf_flags (a same-cycle set wins)
//   evt           event stream (master side)
module debounce_event_arbiter #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned PRESCALE_W = 16,
    parameter logic        RST_VAL    = 1'b0
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     enable,
    input  logic [PRESCALE_W-1:0]    prescale,
    input  logic [CNT_W-1:0]         stable_ticks,
    input  logic [N_CH-1:0]          raw_in,
    output logic [N_CH-1:0]          db_out,
    output logic [N_CH-1:0]          ovf_flags,
    input  logic                     ovf_clr,
    debounce_event_arbiter_if.master evt
);
    localparam int unsigned CH_W = $clog2(N_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    logic [N_CH-1:0]       sync_meta;
    logic [N_CH-1:0]       sync_in;
    logic [PRESCALE_W-1:0] pc;
    logic                  tick;
    logic [CNT_W-1:0]      cnt [N_CH];
    logic [N_CH-1:0]       raise;
    logic [N_CH-1:0]       pending, pending_d;
    logic [N_CH-1:0]       pend_rise, pend_rise_d;
    logic [N_CH-1:0]       ovf_d;
    logic [CH_W-1:0]       rr_ptr;
    logic                  out_valid;
    logic [CH_W-1:0]       out_ch;
    logic                  out_rise;
    logic                  load;
    logic                  found;
    logic [CH_W-1:0]       sel;
    logic [CH_W-1:0]       scan_idx;
    logic [CH_W-1:0]       rr_next;

    assign evt.evt_valid = out_valid;
    assign evt.evt_ch    = out_ch;
    assign evt.evt_rise  = out_rise;

    // Synchroniser
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_meta <= {N_CH{RST_VAL}};
            sync_in   <= {N_CH{RST_VAL}};
        end else begin
            sync_meta <= raw_in;
            sync_in   <= sync_meta;
        end
    end

    // Prescaler; pc > prescale (prescale shrunk mid-count) wraps without a tick.
    assign tick = enable && (pc == prescale);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pc <= '0;
        end else if (!enable || pc >= prescale) begin
            pc <= '0;
        end else begin
            pc <= pc + 1'b1;
        end
    end

    // Debounce: the >= compare caps the count, so it cannot wrap.
    always_comb begin
        raise = '0;
        for (int i = 0; i < N_CH; i++) begin
            raise[i] = tick && (sync_in[i] != db_out[i]) && (cnt[i] >= stable_ticks);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            db_out <= {N_CH{RST_VAL}};
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync_in[i] == db_out[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] >= stable_ticks) begin
                        db_out[i] <= sync_in[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Round-robin pick: first pending channel at or after rr_ptr, with wrap.
    assign load = !out_valid || evt.evt_ready;

    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = rr_ptr;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && pending[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
            scan_idx = (scan_idx == LAST_CH) ? '0 : scan_idx + 1'b1;
        end
    end

    assign rr_next = (sel == LAST_CH) ? '0 : sel + 1'b1;

    // Pending slots: the load clears its slot first, so a same-cycle raise on
    // the loaded channel refills it without counting as an overflow.
    always_comb begin
        pending_d   = pending;
        pend_rise_d = pend_rise;
        ovf_d       = ovf_clr ? '0 : ovf_flags;
        if (load && found) pending_d[sel] = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (raise[i]) begin
                if (pending_d[i]) ovf_d[i] = 1'b1;
                pending_d[i]   = 1'b1;
                pend_rise_d[i] = sync_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pending   <= '0;
            pend_rise <= '0;
            ovf_flags <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_rise  <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            pending   <= pending_d;
            pend_rise <= pend_rise_d;
            ovf_flags <= ovf_d;
            if (load) begin
                if (found) begin
                    out_valid <= 1'b1;
                    out_ch    <= sel;
                    out_rise  <= pend_rise[sel];
                    rr_ptr    <= rr_next;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_debounce_event_arbiter.sv
module tb_debounce_event_arbiter;
    localparam int unsigned N_CH       = 4;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned PRESCALE_W = 16;

    logic                  clk = 1'b0;
    logic                  rstb = 1'b1;
    logic                  enable;
    logic [PRESCALE_W-1:0] prescale;
    logic [CNT_W-1:0]      stable_ticks;
    logic [N_CH-1:0]       raw_in;
    logic [N_CH-1:0]       db_out;
    logic [N_CH-1:0]       ovf_flags;
    logic                  ovf_clr;

    debounce_event_arbiter_if #(.N_CH(N_CH)) evt_if ();

    debounce_event_arbiter #(
        .N_CH(N_CH), .CNT_W(CNT_W), .PRESCALE_W(PRESCALE_W), .RST_VAL(1'b0)
    ) dut (
        .clk(clk), .rstb(rstb), .enable(enable), .prescale(prescale),
        .stable_ticks(stable_ticks), .raw_in(raw_in), .db_out(db_out),
        .ovf_flags(ovf_flags), .ovf_clr(ovf_clr), .evt(evt_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: time base as a cycle counter, each channel as a
    // "ticks seen while input differs" count, and a one-deep mailbox per channel.
    int  m_pc;
    int  m_cnt [N_CH];
    bit  [N_CH-1:0] m_s1, m_sync, m_db, m_pend, m_prise, m_ovf;
    bit  m_valid;
    int  m_rr;
    int  exp_q[$];   // expected delivered events, encoded ch*2+rise
    int  got_ch[$];
    int  got_rise[$];

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_pc = 0; m_s1 = '0; m_sync = '0; m_db = '0; m_pend = '0; m_prise = '0;
            m_ovf = '0; m_valid = 1'b0; m_rr = 0;
            for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
            exp_q.delete();
        end else begin
            bit tk;
            tk = enable && (m_pc == int'(prescale));
            if (enable && m_pc < int'(prescale)) m_pc++;
            else m_pc = 0;
            // delivery slot uses mailboxes as they stood before this edge
            if (!m_valid || evt_if.evt_ready) begin
                m_valid = 1'b0;
                for (int k = 0; k < N_CH; k++) begin
                    int c;
                    c = (m_rr + k) % N_CH;
                    if (m_pend[c]) begin
                        m_valid = 1'b1;
                        m_pend[c] = 1'b0;
                        m_rr = (c + 1) % N_CH;
                        exp_q.push_back(c * 2 + int'(m_prise[c]));
                        break;
                    end
                end
            end
            if (ovf_clr) m_ovf = '0;
            for (int i = 0; i < N_CH; i++) begin
                if (m_sync[i] == m_db[i]) m_cnt[i] = 0;
                else if (tk) begin
                    if (m_cnt[i] >= int'(stable_ticks)) begin
                        m_db[i] = m_sync[i];
                        m_cnt[i] = 0;
                        if (m_pend[i]) m_ovf[i] = 1'b1;
                        m_pend[i] = 1'b1;
                        m_prise[i] = m_sync[i];
                    end else begin
                        m_cnt[i]++;
                    end
                end
            end
            m_sync = m_s1;
            m_s1 = raw_in;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rstb) begin
            check("db_out", 32'(db_out), 32'(m_db));
            check("ovf_flags", 32'(ovf_flags), 32'(m_ovf));
            check("evt_valid", 32'(evt_if.evt_valid), 32'(m_valid));
            if (evt_if.evt_valid && evt_if.evt_ready) begin
                got_ch.push_back(int'(evt_if.evt_ch));
                got_rise.push_back(int'(evt_if.evt_rise));
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL evt_unexpected: got ch %0d rise %0d, required none at %0t",
                             evt_if.evt_ch, evt_if.evt_rise, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("evt_ch", 32'(evt_if.evt_ch), 32'(e / 2));
                    check("evt_rise", 32'(evt_if.evt_rise), 32'(e % 2));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        raw_in = '0;
        rstb = 1'b0;
        step(1);
        rstb = 1'b1;
        step(1);
    endtask

    task automatic clear_log();
        got_ch.delete();
        got_rise.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        enable = 1'b1; prescale = 16'd3; stable_ticks = 8'd2; raw_in = '0;
        ovf_clr = 1'b0; evt_if.evt_ready = 1'b1;
        #1 rstb = 1'b0;
        #10;
        check("rst_db_out", 32'(db_out), 32'd0);
        check("rst_ovf", 32'(ovf_flags), 32'd0);
        check("rst_evt_valid", 32'(evt_if.evt_valid), 32'd0);
        @(posedge clk); #1 rstb = 1'b1;

        // 1: slow tick, ch1 rises and holds: 2 sync + 3 ticks of 4 clk
        clear_log();
        raw_in[1] = 1'b1;
        lat = 0;
        while (db_out[1] !== 1'b1 && lat < 40) begin step(1); lat++; end
        check("s1_db_latency_in_window", 32'(lat >= 11 && lat <= 16), 32'd1);
        step(1);
        check("s1_evt_valid", 32'(evt_if.evt_valid), 32'd1);
        check("s1_evt_ch", 32'(evt_if.evt_ch), 32'd1);
        check("s1_evt_rise", 32'(evt_if.evt_rise), 32'd1);

        // 2: 6-clk glitch on ch0 is rejected
        step(10); clear_log();
        raw_in[0] = 1'b1; step(6); raw_in[0] = 1'b0; step(30);
        check("s2_db0_unchanged", 32'(db_out[0]), 32'd0);
        check("s2_no_event", 32'(got_ch.size()), 32'd0);

        // 3: simultaneous rises, round-robin from ch0, then wrap
        do_reset(); prescale = '0; stable_ticks = '0; clear_log();
        raw_in = 4'b1101; step(10);
        check("s3_count", 32'(got_ch.size()), 32'd3);
        if (got_ch.size() == 3) begin
            check("s3_first", 32'(got_ch[0]), 32'd0);
            check("s3_second", 32'(got_ch[1]), 32'd2);
            check("s3_third", 32'(got_ch[2]), 32'd3);
        end
        clear_log();
        raw_in = 4'b0100; step(10);
        check("s3b_count", 32'(got_ch.size()), 32'd2);
        if (got_ch.size() == 2) begin
            check("s3b_first", 32'(got_ch[0]), 32'd0);
            check("s3b_second", 32'(got_ch[1]), 32'd3);
        end

        // 4: overwrite while output is stalled
        do_reset(); evt_if.evt_ready = 1'b0;
        raw_in[2] = 1'b1; step(6);
        raw_in[1] = 1'b1; step(6);
        raw_in[1] = 1'b0; step(6);
        check("s4_ovf_set", 32'(ovf_flags), 32'b0010);
        clear_log(); evt_if.evt_ready = 1'b1; step(6);
        check("s4_count", 32'(got_ch.size()), 32'd2);
        if (got_ch.size() == 2) begin
            check("s4_ch_a", 32'(got_ch[0]), 32'd2);
            check("s4_ch_b", 32'(got_ch[1]), 32'd1);
            check("s4_rise_b", 32'(got_rise[1]), 32'd0);
        end
        check("s4_ovf_sticky", 32'(ovf_flags), 32'b0010);
        ovf_clr = 1'b1; step(1); ovf_clr = 1'b0; step(1);
        check("s4_ovf_cleared", 32'(ovf_flags), 32'd0);

        // 5: enable low freezes debounce but not delivery
        evt_if.evt_ready = 1'b0;
        raw_in[0] = 1'b1; step(6);
        enable = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) raw_in[2] = ~raw_in[2];
            step(1);
        end
        check("s5_db2_frozen", 32'(db_out[2]), 32'd1);
        check("s5_evt_held", 32'(evt_if.evt_valid), 32'd1);
        clear_log(); evt_if.evt_ready = 1'b1; step(3);
        check("s5_drained", 32'(got_ch.size()), 32'd1);
        if (got_ch.size() == 1) check("s5_drained_ch", 32'(got_ch[0]), 32'd0);
        enable = 1'b1; raw_in[2] = 1'b1; step(5);

        // 6: randomised traffic against the model
        prescale = 16'd2; stable_ticks = 8'd1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N_CH; i++)
                if ($urandom_range(0, 29) == 0) raw_in[i] = ~raw_in[i];
            if ($urandom_range(0, 199) == 0) begin
                prescale = 16'($urandom_range(0, 5));
                stable_ticks = 8'($urandom_range(0, 3));
            end
            evt_if.evt_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 15) != 0);
            ovf_clr = ($urandom_range(0, 49) == 0);
            step(1);
        end
        enable = 1'b1; ovf_clr = 1'b0; evt_if.evt_ready = 1'b1;
        lat = 0;
        while ((evt_if.evt_valid || exp_q.size() != 0) && lat < 300) begin step(1); lat++; end
        check("s6_drain_in_budget", 32'(lat < 300), 32'd1);
        check("s6_queue_empty", 32'(exp_q.size()), 32'd0);

        // 7: asynchronous reset with an event held
        do_reset(); prescale = 16'd3; stable_ticks = 8'd2; evt_if.evt_ready = 1'b0;
        raw_in = 4'b0001;
        lat = 0;
        while (!evt_if.evt_valid && lat < 40) begin step(1); lat++; end
        check("s7_evt_before_reset", 32'(evt_if.evt_valid), 32'd1);
        raw_in = 4'b0011; step(5);
        raw_in = '0;
        #2 rstb = 1'b0;
        #1;
        check("s7_rst_valid", 32'(evt_if.evt_valid), 32'd0);
        check("s7_rst_db", 32'(db_out), 32'd0);
        check("s7_rst_ovf", 32'(ovf_flags), 32'd0);
        check("s7_rst_ch", 32'(evt_if.evt_ch), 32'd0);
        @(posedge clk); #1 rstb = 1'b1;
        clear_log(); evt_if.evt_ready = 1'b1; step(40);
        check("s7_no_stale_event", 32'(got_ch.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
